// File: rtl/digit_grid_sampler.sv
// Reduces a bounding box of the binary frame to a GRID x GRID occupancy bitmap.
// Optional: define GRID_SAMPLER_ABORT_EN to abandon a run when box_valid drops mid-run.
module digit_grid_sampler #(
    parameter int GRID    = 8,
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int MIN_CNT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [19:0]            box_row,
    input  logic [19:0]            box_col,
    input  logic [1:0]             box_valid,
    output logic                   mem_rd,
    output logic [18:0]            mem_addr,
    input  logic                   mem_data,
    output logic [GRID*GRID-1:0]   feature,
    output logic                   feat_valid,
    output logic                   feat_err,
    output logic                   busy
);

    localparam int CW  = 11;
    localparam int CXW = (GRID > 1) ? $clog2(GRID) : 1;
    localparam logic [9:0]    H_L    = 10'(IMG_H);
    localparam logic [9:0]    W_L    = 10'(IMG_W);
    localparam logic [CW-1:0] G_L    = CW'(GRID);
    localparam logic [12:0]   MIN_L  = 13'(MIN_CNT);
    localparam logic [18:0]   W_STEP = 19'(IMG_W);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_DRAIN, S_DONE} state_t;

    state_t         state_q, state_d;
    logic           bv_q;
    logic [9:0]     left_q, left_d;
    logic [9:0]     right_q, right_d;
    logic [9:0]     bottom_q, bottom_d;
    logic [CW-1:0]  w_q, w_d;
    logic [CW-1:0]  h_q, h_d;
    logic [9:0]     col_q, col_d;
    logic [9:0]     row_q, row_d;
    logic [18:0]    addr_q, addr_d;
    logic [18:0]    row_base_q, row_base_d;
    logic [CW-1:0]  cacc_q, cacc_d;
    logic [CW-1:0]  racc_q, racc_d;
    logic [CXW-1:0] cx_q, cx_d;
    logic [CXW-1:0] cy_q, cy_d;
    logic           err_q, err_d;

    logic           v1_q, rend1_q, flush_q;
    logic [CXW-1:0] cx1_q, cy1_q, fcy_q;
    logic [GRID-1:0][12:0] cnt_q, cnt_d;
    logic [GRID-1:0]       row_bits;
    logic [GRID*GRID-1:0]  feature_q;

    logic           bv_all, start, rd, load_go, abort, clr_cnt;
    logic           last_col, last_row, rend, err_c;
    logic [9:0]     top_c, bot_c, left_c, right_c;
    logic [CW-1:0]  w_c, h_c, cacc_sum, racc_sum;

    assign bv_all   = (box_valid == 2'b11);
    assign start    = (state_q == S_IDLE) && en && bv_all && !bv_q;
    assign rd       = (state_q == S_SCAN) && en;
    assign load_go  = (state_q == S_LOAD) && en;
    assign last_col = (col_q == right_q);
    assign last_row = (row_q == bottom_q);
    assign cacc_sum = cacc_q + G_L;
    assign racc_sum = racc_q + G_L;
    // Last pixel of the last image row belonging to the current cell row.
    assign rend     = last_col && (racc_sum >= h_q);
    assign clr_cnt  = load_go || abort;

`ifdef GRID_SAMPLER_ABORT_EN
    assign abort = ((state_q == S_LOAD) || (state_q == S_SCAN) || (state_q == S_DRAIN)) && !bv_all;
`else
    assign abort = 1'b0;
`endif

    // Out-of-range top/left come from an upstream offset that wrapped below zero.
    always_comb begin
        top_c   = (box_row[9:0]   >= H_L) ? 10'd0 : box_row[9:0];
        bot_c   = (box_row[19:10] >= H_L) ? H_L - 10'd1 : box_row[19:10];
        left_c  = (box_col[9:0]   >= W_L) ? 10'd0 : box_col[9:0];
        right_c = (box_col[19:10] >= W_L) ? W_L - 10'd1 : box_col[19:10];
        w_c     = {1'b0, right_c} - {1'b0, left_c} + 11'd1;
        h_c     = {1'b0, bot_c} - {1'b0, top_c} + 11'd1;
        err_c   = (bot_c < top_c) || (right_c < left_c) || (w_c < G_L) || (h_c < G_L);
    end

    always_comb begin
        state_d    = state_q;
        left_d     = left_q;
        right_d    = right_q;
        bottom_d   = bottom_q;
        w_d        = w_q;
        h_d        = h_q;
        col_d      = col_q;
        row_d      = row_q;
        addr_d     = addr_q;
        row_base_d = row_base_q;
        cacc_d     = cacc_q;
        racc_d     = racc_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (en) begin
                    left_d     = left_c;
                    right_d    = right_c;
                    bottom_d   = bot_c;
                    w_d        = w_c;
                    h_d        = h_c;
                    col_d      = left_c;
                    row_d      = top_c;
                    // Constant-coefficient product: shifts and adds only.
                    row_base_d = 19'(top_c) * W_STEP;
                    addr_d     = (19'(top_c) * W_STEP) + {9'd0, left_c};
                    cacc_d     = '0;
                    racc_d     = '0;
                    cx_d       = '0;
                    cy_d       = '0;
                    err_d      = err_c;
                    state_d    = err_c ? S_DONE : S_SCAN;
                end
            end
            S_SCAN: begin
                if (en) begin
                    if (cacc_sum >= w_q) begin
                        cacc_d = cacc_sum - w_q;
                        cx_d   = cx_q + CXW'(1);
                    end else begin
                        cacc_d = cacc_sum;
                    end
                    if (last_col) begin
                        cacc_d     = '0;
                        cx_d       = '0;
                        col_d      = left_q;
                        row_d      = row_q + 10'd1;
                        row_base_d = row_base_q + W_STEP;
                        addr_d     = row_base_q + W_STEP + {9'd0, left_q};
                        if (racc_sum >= h_q) begin
                            racc_d = racc_sum - h_q;
                            cy_d   = cy_q + CXW'(1);
                        end else begin
                            racc_d = racc_sum;
                        end
                        if (last_row) state_d = S_DRAIN;
                    end else begin
                        col_d  = col_q + 10'd1;
                        addr_d = addr_q + 19'd1;
                    end
                end
            end
            S_DRAIN: begin
                // The final flush completes on the same edge that enters DONE.
                if (en && !v1_q) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            bv_q       <= 1'b1;   // a level already high out of reset must drop before it can start a run
            left_q     <= '0;
            right_q    <= '0;
            bottom_q   <= '0;
            w_q        <= '0;
            h_q        <= '0;
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            row_base_q <= '0;
            cacc_q     <= '0;
            racc_q     <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bv_q       <= bv_all;
            left_q     <= left_d;
            right_q    <= right_d;
            bottom_q   <= bottom_d;
            w_q        <= w_d;
            h_q        <= h_d;
            col_q      <= col_d;
            row_q      <= row_d;
            addr_q     <= addr_d;
            row_base_q <= row_base_d;
            cacc_q     <= cacc_d;
            racc_q     <= racc_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q    <= 1'b0;
            cx1_q   <= '0;
            cy1_q   <= '0;
            rend1_q <= 1'b0;
            flush_q <= 1'b0;
            fcy_q   <= '0;
        end else begin
            v1_q    <= rd && !abort;
            cx1_q   <= cx_q;
            cy1_q   <= cy_q;
            rend1_q <= rend;
            flush_q <= v1_q && rend1_q && !abort;
            fcy_q   <= cy1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < GRID; gi++) begin : g_cell
            logic [12:0] base;
            logic        hit;
            // A flush and the next cell row's first datum may land in the same cycle.
            assign base          = flush_q ? 13'd0 : cnt_q[gi];
            assign hit           = v1_q && !mem_data && (cx1_q == CXW'(gi));
            assign cnt_d[gi]     = clr_cnt ? 13'd0
                                 : ((hit && (base != 13'h1fff)) ? base + 13'd1 : base);
            assign row_bits[gi]  = (cnt_q[gi] >= MIN_L);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            feature_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (clr_cnt) begin
                feature_q <= '0;
            end else if (flush_q) begin
                feature_q[fcy_q*GRID +: GRID] <= row_bits;
            end
        end
    end

    assign mem_rd     = rd;
    assign mem_addr   = addr_q;
    assign feature    = feature_q;
    assign feat_valid = (state_q == S_DONE);
    assign feat_err   = err_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: doc/digit_grid_sampler.md
# digit_grid_sampler

Downstream of the row/column edge-detection stage: once both bounding-box edges are final, reads the boxed region from the binary frame RAM and reduces it to a GRID×GRID occupancy bitmap for the digit classifier. Division-free: pixels map to cells with Bresenham-style accumulators, and each cell's foreground count is thresholded.

## Interface
- GRID, 8: cells per side; feature width GRID*GRID
- IMG_W, 640: frame width in pixels
- IMG_H, 480: frame height in pixels
- MIN_CNT, 2: minimum foreground pixels for a cell bit to be 1
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- en  in  1  advance enable; low freezes FSM and read issue
- box_row  in  20  [9:0] top row, [19:10] bottom row
- box_col  in  20  [9:0] left col, [19:10] right col
- box_valid  in  2  both bits 1 = box final (upstream finish flags)
- mem_rd  out  1  read strobe
- mem_addr  out  19  row*IMG_W + col
- mem_data  in  1  pixel, valid exactly 1 cycle after mem_rd; 0 = foreground
- feature  out  GRID*GRID  bit cy*GRID+cx; cx=0 left, cy=0 top
- feat_valid  out  1  one-cycle pulse, feature/feat_err valid
- feat_err  out  1  box rejected; feature forced 0
- busy  out  1  high outside IDLE

## Operation
- Start: rising edge of (box_valid==2'b11), sampled while en=1 in IDLE. Level held high does not retrigger; must drop to re-arm.
- FSM: IDLE → LOAD → SCAN → DRAIN → DONE → IDLE; LOAD → DONE on error.
- LOAD (1 cycle): clamp. top/left ≥ IMG_H/IMG_W (offset underflow wrap) → 0; bottom ≥ IMG_H → IMG_H-1; right ≥ IMG_W → IMG_W-1. w=right-left+1, h=bottom-top+1. Error if bottom<top, right<left, w<GRID or h<GRID.
- SCAN: raster order over box, one mem_rd per enabled cycle; row_base incremented by IMG_W per row (no multiplier). Column accumulator += GRID per pixel; when ≥ w, subtract w, cx++. Same per row for cy with h; cx/acc reset each row.
- cx, cy, and a cell-row-end flag are delayed 1 cycle to pair with mem_data. GRID counters (13-bit, saturating) accumulate (mem_data==0).
- On cell-row end (last pixel of last image row mapping to cy): feature[cy*GRID +: GRID] ← (cnt ≥ MIN_CNT) per cx; counters cleared.
- DRAIN: waits for final datum and its flush. DONE: feat_valid=1 for one cycle.
- en=0: mem_rd=0, counters frozen; a datum already in flight is still accumulated.
- feature held until next start; cleared to 0 at LOAD.

## Timing
- Reset values: mem_rd=0, mem_addr=0, feature=0, feat_valid=0, feat_err=0, busy=0, FSM=IDLE.
- Start edge at cycle 0: LOAD cycle 1, reads cycles 2..N+1 (N=w*h), last data N+2, flush N+3, feat_valid in cycle N+4 (en held high); each en-low cycle adds one.
- Error path: feat_valid with feat_err=1 in cycle 2.
- Async reset mid-scan: immediate return to reset values; no feat_valid.

## Configuration
- GRID_SAMPLER_ABORT_EN defined: box_valid leaving 2'b11 during LOAD/SCAN/DRAIN → IDLE next cycle, mem_rd=0, no feat_valid, feature=0.
- Undefined: box_valid ignored after start; scan always completes.

## Test plan
- Box rows 100..163, cols 200..263; RAM all 1 except 0s at rows 100–107, cols 200–207 → feature=64'h1, feat_valid at cycle 4100, mem_addr first = 64200.
- Same box, single 0 pixel at (163,263) → feature=0 (MIN_CNT=2); two 0s at (162,263),(163,263) → bit 63 set.
- top=10'd1020, bottom=63, left=0, right=63, RAM all 0 → clamps to 0, feature=all ones, first mem_addr=0.
- right-left+1=5 → feat_err=1, feature=0, feat_valid in cycle 2, no mem_rd.
- en low for 10 cycles mid-SCAN → identical feature, feat_valid 10 cycles later; rst low mid-SCAN → outputs at reset values, no feat_valid, restart needs new box_valid edge.
- With GRID_SAMPLER_ABORT_EN, box_valid→2'b01 mid-SCAN → busy=0 next cycle, no feat_valid; without, normal completion.
